// File: rtl/result_skid_buffer.sv
// result_skid_buffer
// Two-entry registered skid buffer sitting after the 4:1 result mux.
// Holds up to two results (data + select tag) in strict FIFO order and
// presents the oldest one to the writeback stage. Every output is a register,
// so nothing on in_* reaches out_* in the same cycle, and in_ready never
// depends on out_ready combinationally.
//
// Handshake rules (both sides use the same valid/ready contract):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - Once valid is raised, the payload stays stable and valid stays high
//     until that transfer happens. Reset is the only exception.
//   - ready may change at any time. The payload is ignored in any cycle where
//     no transfer takes place.
module result_skid_buffer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_count
);

  // The state encoding is the number of entries held.
  // The skid entry is valid exactly when the state is ST_FULL.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main_data;
  logic [TAG_W-1:0] r_main_tag;
  logic [WIDTH-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_xfer_count;

  logic w_acc;
  logic w_pop;

  // Accept and pop strobes. Both are built only from registered outputs.
  assign w_acc = in_valid && r_in_ready;
  assign w_pop = r_out_valid && out_ready;

  // Main occupancy FSM. It moves the main and skid entries and drives the
  // registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_tag  <= '0;
      r_skid_data <= '0;
      r_skid_tag  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main_data <= in_data;
            r_main_tag  <= in_tag;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            // Pass-through: the new result replaces the one just consumed.
            r_main_data <= in_data;
            r_main_tag  <= in_tag;
          end else if (w_acc) begin
            // Consumer stalled: park the younger result in the skid entry.
            r_skid_data <= in_data;
            r_skid_tag  <= in_tag;
            r_in_ready  <= 1'b0;
            r_state     <= ST_FULL;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is 0 here, so only a pop can move the state.
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_tag  <= r_skid_tag;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  // Count accepted input transfers. The counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_acc) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main_data;
  assign out_tag    = r_main_tag;
  assign occupancy  = r_state;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_result_skid_buffer.sv
// tb_result_skid_buffer
// Directed bench for result_skid_buffer. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at the same point, so each step
// shows the effect of exactly one clock edge.
module tb_result_skid_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_tag;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count;

  int n_pass;
  int n_total;

  result_skid_buffer #(.WIDTH(32), .TAG_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock edge, then move 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset values.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);

    // A single result goes through with latency 1.
    in_valid = 1'b1; in_data = 32'h0000_00A5; in_tag = 2'd2; out_ready = 1'b1;
    step();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data", out_data, 32'h0000_00A5);
    check("t1_out_tag", 32'(out_tag), 32'd2);
    check("t1_occ", 32'(occupancy), 32'd1);
    check("t1_xfer", 32'(xfer_count), 32'd1);
    in_valid = 1'b0;
    step();
    check("t1_drain_valid", 32'(out_valid), 32'd0);
    check("t1_drain_occ", 32'(occupancy), 32'd0);

    // Stream 8 results back to back with no stall.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_tag = 2'(i);
      step();
      check("t2_out_data", out_data, 32'(i));
      check("t2_out_tag", 32'(out_tag), 32'(i % 4));
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_in_ready", 32'(in_ready), 32'd1);
      check("t2_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    check("t2_xfer", 32'(xfer_count), 32'd8);
    step();
    check("t2_drain_valid", 32'(out_valid), 32'd0);

    // Fill both entries while the consumer is stalled. The count is now 8.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_tag = 2'd1;
    step();
    check("t3_occ1", 32'(occupancy), 32'd1);
    check("t3_ready1", 32'(in_ready), 32'd1);
    check("t3_data1", out_data, 32'h11);
    in_data = 32'h22; in_tag = 2'd3;
    step();
    check("t3_occ2", 32'(occupancy), 32'd2);
    check("t3_ready2", 32'(in_ready), 32'd0);
    check("t3_data_held", out_data, 32'h11);
    check("t3_tag_held", 32'(out_tag), 32'd1);
    check("t3_xfer", 32'(xfer_count), 32'd10);

    // While FULL, an offered value is ignored for 3 cycles.
    in_data = 32'hDEAD_BEEF; in_tag = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_data_stable", out_data, 32'h11);
      check("t4_tag_stable", 32'(out_tag), 32'd1);
      check("t4_occ", 32'(occupancy), 32'd2);
      check("t4_ready", 32'(in_ready), 32'd0);
      check("t4_xfer", 32'(xfer_count), 32'd10);
    end

    // Release the stall: 0x11 pops first, then 0x22 is presented.
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t3_pop1_data", out_data, 32'h22);
    check("t3_pop1_tag", 32'(out_tag), 32'd3);
    check("t3_pop1_ready", 32'(in_ready), 32'd1);
    check("t3_pop1_occ", 32'(occupancy), 32'd1);
    step();
    check("t3_pop2_valid", 32'(out_valid), 32'd0);
    check("t3_pop2_occ", 32'(occupancy), 32'd0);
    check("t3_pop2_xfer", 32'(xfer_count), 32'd10);

    // Fill again, then assert reset asynchronously in the middle of a cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h33; in_tag = 2'd2;
    step();
    in_data = 32'h44; in_tag = 2'd1;
    step();
    in_valid = 1'b0;
    check("t5_pre_occ", 32'(occupancy), 32'd2);
    check("t5_pre_xfer", 32'(xfer_count), 32'd12);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_occ", 32'(occupancy), 32'd0);
    check("t5_async_ready", 32'(in_ready), 32'd1);
    check("t5_async_xfer", 32'(xfer_count), 32'd0);
    check("t5_async_data", out_data, 32'd0);
    #1;
    reset = 1'b0;
    step();
    check("t5_post_valid", 32'(out_valid), 32'd0);

    // Preload the counter to 0xFFFF, then make one more accept to wrap it.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      in_data = 32'(i); in_tag = 2'(i);
      step();
    end
    check("t6_pre_xfer", 32'(xfer_count), 32'hFFFF);
    check("t6_pre_data", out_data, 32'd65535);
    in_data = 32'hCAFE_0001; in_tag = 2'd1;
    step();
    check("t6_wrap_xfer", 32'(xfer_count), 32'd0);
    check("t6_wrap_data", out_data, 32'hCAFE_0001);
    check("t6_wrap_tag", 32'(out_tag), 32'd1);
    check("t6_wrap_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("t6_drain_occ", 32'(occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
